// File: rtl/seq_rca_adder.sv
// seq_rca_adder: multi-cycle ripple-carry adder.
//
// Computes {cout, s} = a + b + cin (unsigned, WIDTH bits) by adding CHUNK
// bits per clock. The carry is registered between chunks, so the critical
// path is a single CHUNK-bit ripple. Valid/ready handshake on both sides.
//
// Parameters:
//   WIDTH  operand/sum width (>= 1)
//   CHUNK  bits added per cycle (>= 1, must divide WIDTH)
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid, in_ready  operand handshake (a, b, cin taken on in_valid & in_ready)
//   a, b, cin           operands and carry-in
//   out_valid, out_ready result handshake
//   s, cout             sum and carry-out, held until the next result is loaded
//   ovf                 signed overflow (only with SEQ_RCA_ADDER_OVF_EN defined)
//   busy                high whenever the FSM is not idle
//
// Optional macro SEQ_RCA_ADDER_OVF_EN adds the ovf output.

module seq_rca_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
`ifdef SEQ_RCA_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic             busy
);

    localparam int NCHUNK = (CHUNK > 0) ? (WIDTH / CHUNK) : 1;
    localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
        $error("seq_rca_adder: WIDTH must be >= 1 and CHUNK >= 1 must divide WIDTH");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state, state_nxt;

    logic [WIDTH-1:0]   a_r, b_r;
    logic [WIDTH-1:0]   acc, acc_nxt;
    logic               carry;
    logic [CNT_W-1:0]   cnt;
    logic               last;
    logic [CHUNK:0]     csum;

    assign last = (cnt == CNT_W'(NCHUNK - 1));

    // One chunk of ripple per cycle; acc_nxt is the accumulator with the
    // current chunk merged in, so the final edge can load s directly.
    always_comb begin
        csum = {1'b0, a_r[cnt*CHUNK +: CHUNK]}
             + {1'b0, b_r[cnt*CHUNK +: CHUNK]}
             + {{CHUNK{1'b0}}, carry};
        acc_nxt = acc;
        acc_nxt[cnt*CHUNK +: CHUNK] = csum[CHUNK-1:0];
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state and state-decoded handshake outputs
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_nxt = ADD;
            end
            ADD: begin
                if (last) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                busy      = 1'b0;
            end
        endcase
    end

    // Datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r   <= '0;
            b_r   <= '0;
            acc   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            s     <= '0;
            cout  <= 1'b0;
`ifdef SEQ_RCA_ADDER_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r   <= a;
                        b_r   <= b;
                        carry <= cin;
                        cnt   <= '0;
                    end
                end
                ADD: begin
                    acc   <= acc_nxt;
                    carry <= csum[CHUNK];
                    cnt   <= cnt + 1'b1;
                    if (last) begin
                        s    <= acc_nxt;
                        cout <= csum[CHUNK];
`ifdef SEQ_RCA_ADDER_OVF_EN
                        // Carry into the MSB recovered from the MSB sum bit
                        // (sum = a ^ b ^ carry_in); overflow when it differs
                        // from the carry out of the MSB.
                        ovf  <= (acc_nxt[WIDTH-1] ^ a_r[WIDTH-1] ^ b_r[WIDTH-1])
                                ^ csum[CHUNK];
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/seq_rca_adder.md
Name: seq_rca_adder

Overview:
Parametrised multi-cycle ripple-carry adder. It adds two WIDTH-bit operands plus a carry-in, CHUNK bits per clock. The carry is registered between chunks, so the critical path is one CHUNK-bit ripple instead of WIDTH bits. It replaces fixed-width combinational adders in datapaths that can tolerate latency, and uses a valid/ready handshake on both input and output.

Parameters:
WIDTH, 16, operand and sum width in bits; must be at least 1.
CHUNK, 4, bits added per cycle; must be at least 1 and divide WIDTH exactly. Otherwise elaboration fails with $error.
NCHUNK, WIDTH/CHUNK, derived (localparam); number of ADD cycles.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands a, b, cin are valid
in_ready  output  1  block can accept operands
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in to bit 0
out_valid  output  1  s and cout hold a completed result
out_ready  input  1  consumer accepts the result
s  output  WIDTH  sum (a + b + cin) mod 2^WIDTH
cout  output  1  carry out of bit WIDTH-1
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (async assert, sync release): state=IDLE, chunk counter=0, carry reg=0, in_ready=1, out_valid=0, s=0, cout=0, busy=0.
- FSM states: IDLE, ADD, DONE. All outputs are registered or decoded from state only; no combinational path from inputs to outputs.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready: capture a, b, cin into internal regs; cnt=0; carry=cin; go to ADD.
- ADD (in_ready=0, busy=1):
  - Each cycle: {carry, acc[cnt*CHUNK +: CHUNK]} <= a_r chunk + b_r chunk + carry.
  - cnt increments each cycle.
  - At cnt==NCHUNK-1: load s <= final acc and cout <= final carry in the same edge; set out_valid=1; go to DONE.
- Latency: if the handshake edge is T, out_valid rises at edge T+NCHUNK.
  - CHUNK==WIDTH gives 1 cycle.
  - CHUNK==1 gives a bit-serial adder with WIDTH cycles.
- DONE:
  - out_valid=1; s and cout held stable.
  - On out_valid & out_ready: out_valid=0 and state=IDLE; in_ready returns to 1 on the following cycle.
  - No accept in the same cycle as the result handoff.
- s/cout change only when a new result is loaded. They keep the last result after handoff and are not updated during ADD.
- Input changes on a, b, cin or in_valid while not in IDLE are ignored. Operands are taken only at the handshake.
- Arithmetic is unsigned modulo 2^WIDTH; cout is bit WIDTH of the full-precision sum. Carry ripples correctly across chunk boundaries, e.g. all-ones + 1.
- Reset mid-ADD or mid-DONE aborts immediately: the result is lost and all outputs return to reset values.

Optional Feature:
Macro: SEQ_RCA_ADDER_OVF_EN
- Defined:
  - Adds output port ovf (1 bit) = signed two's-complement overflow = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
  - The MSB-1 carry is captured during the last ADD cycle.
  - ovf is loaded and held alongside s/cout, and reset to 0.
- Not defined: the ovf port and its logic are absent; all other behaviour is identical.

Test Plan:
(WIDTH=16, CHUNK=4 unless stated)
1. a=6, b=6, cin=0, handshake at edge T -> out_valid=1 at T+4, s=16'd12, cout=0; in_ready=0 and busy=1 throughout.
2. a=16'hFFFF, b=16'h0001, cin=0 -> s=16'h0000, cout=1 (carry crosses all 3 chunk boundaries). Repeat with a=16'h0FFF, b=0, cin=1 -> s=16'h1000, cout=0.
3. Backpressure: a=12, b=11 with out_ready=0 for 6 cycles after out_valid -> s=16'd23, cout=0 stable and in_ready=0 for all 6 cycles; a new in_valid pulse with a=1 during DONE is ignored. Raise out_ready -> out_valid drops next edge, then in_ready=1.
4. Assert rst_n=0 two cycles into ADD -> out_valid=0, s=0, cout=0, busy=0, in_ready=1 immediately. After release, a=3, b=4 gives s=7 with normal latency.
5. Parameter sweep CHUNK=16 and CHUNK=1 with a=16'hA5A5, b=16'h5A5B, cin=0 -> s=16'h0000, cout=1; latency 1 and 16 cycles respectively.
6. With SEQ_RCA_ADDER_OVF_EN:
   - a=16'h7FFF, b=1 -> s=16'h8000, ovf=1, cout=0.
   - a=16'h8000, b=16'h8000 -> s=0, ovf=1, cout=1.
   - a=16'hFFFF, b=1 -> ovf=0, cout=1.
